// File: rtl/tone_envelope_generator_if.sv
// tone_envelope_generator_if: pitch/tick inputs and sample output between period calculator, envelope and serializer.
interface tone_envelope_generator_if #(
    parameter int SAMPLE_W = 16,
    parameter int PERIOD_W = 10
);
    logic [PERIOD_W-1:0] tone_half_period;
    logic                sample_req;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    modport master (output tone_half_period, sample_req, input sample, sample_valid);
    modport slave (input tone_half_period, sample_req, output sample, sample_valid);
endinterface

// File: rtl/tone_envelope_generator.sv
// tone_envelope_generator: square-wave oscillator with linear attack/sustain/release envelope, one sample per tick.
module tone_envelope_generator #(
    parameter int SAMPLE_W     = 16,
    parameter int PERIOD_W     = 10,
    parameter int AMP_MAX      = 12000,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 32
) (
    input logic clk,
    input logic rst,
    tone_envelope_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
    localparam logic [SAMPLE_W:0]   AMAX  = (SAMPLE_W+1)'(AMP_MAX);
    localparam logic [SAMPLE_W:0]   ASTEP = (SAMPLE_W+1)'(ATTACK_STEP);
    localparam logic [SAMPLE_W:0]   RSTEP = (SAMPLE_W+1)'(RELEASE_STEP);
    localparam logic [SAMPLE_W-1:0] ATOP  = SAMPLE_W'(AMP_MAX);
    localparam logic [SAMPLE_W-1:0] AINIT = ASTEP > AMAX ? ATOP : SAMPLE_W'(ATTACK_STEP);
    state_t state, state_n;
    logic [SAMPLE_W-1:0] level, level_n, up, dn, out;
    logic [SAMPLE_W:0] up_raw, dn_raw;
    logic [PERIOD_W-1:0] hp, held_hp, held_n, cnt, cnt_n;
    logic key, pol, pol_n, restart, wrap;
    always_comb begin
        hp = bus.tone_half_period;
        key = |hp;
        held_n = key ? hp : held_hp;
        up_raw = {1'b0, level} + ASTEP;
        up = up_raw > AMAX ? ATOP : up_raw[SAMPLE_W-1:0];
        dn_raw = {1'b0, level} - RSTEP;
        dn = dn_raw[SAMPLE_W] ? '0 : dn_raw[SAMPLE_W-1:0];
        state_n = state;
        level_n = level;
        case (state)
            IDLE: begin
                state_n = key ? ATTACK : IDLE;
                level_n = key ? AINIT : '0;
            end
            ATTACK: begin
                state_n = !key ? RELEASE : (up == ATOP ? SUSTAIN : ATTACK);
                level_n = key ? up : dn;
            end
            SUSTAIN: begin
                state_n = key ? SUSTAIN : RELEASE;
                level_n = key ? ATOP : dn;
            end
            default: begin
                state_n = key ? ATTACK : (dn == '0 ? IDLE : RELEASE);
                level_n = key ? up : dn;
            end
        endcase
        // a fresh key press restarts the phase; retrigger from RELEASE does not
        restart = state == IDLE && key;
        wrap = cnt >= held_n - PERIOD_W'(1);
        cnt_n = restart ? '0 : (held_n == '0 ? cnt : (wrap ? '0 : cnt + PERIOD_W'(1)));
        pol_n = restart ? 1'b1 : (held_n != '0 && wrap ? ~pol : pol);
        out = state_n == IDLE ? '0 : (pol_n ? level_n : -level_n);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
            cnt <= '0;
            pol <= 1'b0;
            held_hp <= '0;
            bus.sample <= '0;
            bus.sample_valid <= 1'b0;
        end else begin
            bus.sample_valid <= bus.sample_req;
            if (bus.sample_req) begin
                state <= state_n;
                level <= level_n;
                cnt <= cnt_n;
                pol <= pol_n;
                held_hp <= held_n;
                bus.sample <= out;
            end
        end
    end
endmodule
